// File: rtl/register_file_if.sv
// Bus bundle for the three-port register file: two combinational read ports
// and one synchronous write port.
`timescale 1ns/1ps
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  we3;
  logic [ADDR_WIDTH-1:0] a1;
  logic [ADDR_WIDTH-1:0] a2;
  logic [ADDR_WIDTH-1:0] a3;
  logic [DATA_WIDTH-1:0] wd3;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  modport master (
    output we3, a1, a2, a3, wd3,
    input  rd1, rd2
  );

  modport slave (
    input  we3, a1, a2, a3, wd3,
    output rd1, rd2
  );
endinterface

// File: rtl/register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file: two combinational reads, one
// clocked write, register 0 hardwired to zero, asynchronous active-high clear.
`timescale 1ns/1ps
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave bus
);

  localparam int REG_COUNT = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  write_hit;

  // An X/Z enable evaluates false here, so such an edge never writes.
  assign write_hit = (bus.we3 == 1'b1) && (bus.a3 != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[bus.a3] <= bus.wd3;
    end
  end

  // No write bypass: reads see the stored value, so a same-cycle write shows
  // up only after the edge.
  assign bus.rd1 = (bus.a1 == '0) ? '0 : regs[bus.a1];
  assign bus.rd2 = (bus.a2 == '0) ? '0 : regs[bus.a2];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read data is queued when the
// read address is driven and popped when the combinational output is sampled.
`timescale 1ns/1ps
module tb_register_file;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we3 = 1'b1;
    bus.a3  = a;
    bus.wd3 = d;
    @(posedge clk);
    #1;
    bus.we3 = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    logic [31:0] exp;
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 32; i += 5) begin
      @(negedge clk);
      bus.a1 = 5'(i);
      bus.a2 = 5'(31 - i);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      #1;
      got = bus.rd1; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL reset_rd1 a=%0d got=%h want=%h", i, got, exp); end
      got = bus.rd2; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL reset_rd2 a=%0d got=%h want=%h", 31 - i, got, exp); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] got;
    logic [31:0] exp;
    do_write(5'd2, 32'hDEADBEEF);
    @(negedge clk);
    bus.a1 = 5'd2;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    got = bus.rd1; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL basic_rd1 got=%h want=%h", got, exp); end
  endtask

  task automatic test_reg0();
    logic [31:0] got;
    logic [31:0] exp;
    do_write(5'd0, 32'd3);
    @(negedge clk);
    bus.a1 = 5'd0;
    bus.a2 = 5'd0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    got = bus.rd2; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reg0_rd2 got=%h want=%h", got, exp); end
    got = bus.rd1; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reg0_rd1 got=%h want=%h", got, exp); end
  endtask

  task automatic test_write_disabled();
    logic [31:0] got;
    logic [31:0] exp;
    do_write(5'd3, 32'd5);
    @(negedge clk);
    bus.we3 = 1'b0;
    bus.a3  = 5'd3;
    bus.wd3 = 32'd1;
    @(negedge clk);
    bus.a1 = 5'd3;
    exp_q.push_back(32'd5);
    #1;
    got = bus.rd1; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL we_off_rd1 got=%h want=%h", got, exp); end
  endtask

  task automatic test_dual_read();
    logic [31:0] got;
    logic [31:0] exp;
    do_write(5'd1, 32'h11);
    do_write(5'd2, 32'h22);
    @(negedge clk);
    bus.a1 = 5'd1;
    bus.a2 = 5'd2;
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    #1;
    got = bus.rd1; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL dual_rd1 got=%h want=%h", got, exp); end
    got = bus.rd2; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL dual_rd2 got=%h want=%h", got, exp); end
    // Same address on both ports.
    bus.a2 = 5'd1;
    exp_q.push_back(32'h11);
    #1;
    got = bus.rd2; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL same_addr_rd2 got=%h want=%h", got, exp); end
    // Old value before the write edge, new value after it.
    @(negedge clk);
    bus.we3 = 1'b1;
    bus.a3  = 5'd1;
    bus.wd3 = 32'h99;
    bus.a1  = 5'd1;
    exp_q.push_back(32'h11);
    #1;
    got = bus.rd1; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL old_value_rd1 got=%h want=%h", got, exp); end
    @(posedge clk);
    #1;
    bus.we3 = 1'b0;
    model[1] = 32'h99;
    exp_q.push_back(32'h99);
    got = bus.rd1; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL new_value_rd1 got=%h want=%h", got, exp); end
  endtask

  task automatic test_async_reset();
    logic [31:0] got;
    logic [31:0] exp;
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA500_0000 | 32'(i));
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    #0.5;
    // All 32 addresses checked well before the next rising edge.
    for (int i = 0; i < 32; i++) begin
      bus.a1 = 5'(i);
      bus.a2 = 5'(31 - i);
      exp_q.push_back(model_read(5'(i)));
      exp_q.push_back(model_read(5'(31 - i)));
      #0.1;
      got = bus.rd1; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL async_rst_rd1 a=%0d got=%h want=%h", i, got, exp); end
      got = bus.rd2; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL async_rst_rd2 a=%0d got=%h want=%h", 31 - i, got, exp); end
    end
    // Write attempted while reset is held must be dropped.
    @(negedge clk);
    bus.we3 = 1'b1;
    bus.a3  = 5'd4;
    bus.wd3 = 32'd7;
    @(posedge clk);
    #1;
    bus.we3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.a1 = 5'd4;
    exp_q.push_back(32'd0);
    #1;
    got = bus.rd1; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL rst_priority_rd1 got=%h want=%h", got, exp); end
    // First enabled edge after release writes normally.
    do_write(5'd4, 32'd7);
    exp_q.push_back(32'd7);
    #1;
    got = bus.rd1; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL post_rst_write_rd1 got=%h want=%h", got, exp); end
  endtask

  task automatic test_sweep();
    logic [31:0] got;
    logic [31:0] exp;
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i + 1));
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.a1 = 5'(i);
      bus.a2 = 5'(i);
      exp_q.push_back((i == 0) ? 32'd0 : 32'(i + 1));
      exp_q.push_back((i == 0) ? 32'd0 : 32'(i + 1));
      #1;
      got = bus.rd1; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL sweep_rd1 a=%0d got=%h want=%h", i, got, exp); end
      got = bus.rd2; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL sweep_rd2 a=%0d got=%h want=%h", i, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    logic [31:0] exp;
    logic [4:0]  a;
    logic [31:0] d;
    // One write per consecutive edge, no idle cycles in between.
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      bus.we3 = 1'b1;
      bus.a3  = a;
      bus.wd3 = d;
      @(posedge clk);
      if (a != 5'd0) model[a] = d;
      @(negedge clk);
    end
    bus.we3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.a1 = 5'(i);
      bus.a2 = 5'(31 - i);
      exp_q.push_back(model_read(5'(i)));
      exp_q.push_back(model_read(5'(31 - i)));
      #1;
      got = bus.rd1; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL b2b_rd1 a=%0d got=%h want=%h", i, got, exp); end
      got = bus.rd2; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL b2b_rd2 a=%0d got=%h want=%h", 31 - i, got, exp); end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.we3 = 1'b0;
    bus.a1  = '0;
    bus.a2  = '0;
    bus.a3  = '0;
    bus.wd3 = '0;
    model_clear();
    test_reset();
    test_basic();
    test_reg0();
    test_write_disabled();
    test_dual_read();
    test_async_reset();
    test_sweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
